// File: rtl/sha3_absorb.sv
// Absorb front end for the chained Keccak round pipeline: collects one rate block
// of message lanes and XORs it into the chaining state, then waits for the permuted state.
module sha3_absorb #(
  parameter int RATE_LANES = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] lane_in,
  input  logic        lane_valid,
  output logic        lane_ready,
  input  logic        msg_last,
  input  logic [63:0] fba [0:4],
  input  logic [63:0] fbb [0:4],
  input  logic [63:0] fbc [0:4],
  input  logic [63:0] fbd [0:4],
  input  logic [63:0] fbe [0:4],
  input  logic        fb_good,
  output logic [63:0] osa [0:4],
  output logic [63:0] osb [0:4],
  output logic [63:0] osc [0:4],
  output logic [63:0] osd [0:4],
  output logic [63:0] ose [0:4],
  output logic        good,
  output logic        busy
);

  if (RATE_LANES < 1 || RATE_LANES > 25) begin : g_bad_rate
    $error("sha3_absorb: RATE_LANES must be in 1..25");
  end

  localparam int IDX_W = $clog2(RATE_LANES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT_FB = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             lane_fire_s, issue_s, fb_take_s;

  logic [63:0] chain_q    [0:24];
  logic [63:0] lane_buf_q [0:RATE_LANES-1];
  logic [63:0] os_q       [0:24];
  logic        good_q;

  logic [63:0] fb_s      [0:24];
  logic [63:0] os_next_s [0:24];

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    lane_fire_s = 1'b0;
    issue_s     = 1'b0;
    fb_take_s   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (lane_valid && !rst) begin
          lane_fire_s = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            last_d  = msg_last;
            state_d = ISSUE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ISSUE: begin
        issue_s = 1'b1;
        state_d = WAIT_FB;
      end
      WAIT_FB: begin
        if (fb_good) begin
          fb_take_s = 1'b1;
          state_d   = COLLECT;
        end else begin
          state_d = WAIT_FB;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  // Flatten the feedback rows and form the issued matrix (rate lanes get the block XORed in).
  always_comb begin
    for (int c = 0; c < 5; c++) begin
      fb_s[c]      = fba[c];
      fb_s[5 + c]  = fbb[c];
      fb_s[10 + c] = fbc[c];
      fb_s[15 + c] = fbd[c];
      fb_s[20 + c] = fbe[c];
    end
    for (int i = 0; i < 25; i++) begin
      os_next_s[i] = chain_q[i];
    end
    for (int i = 0; i < RATE_LANES; i++) begin
      os_next_s[i] = chain_q[i] ^ lane_buf_q[i];
    end
  end

  // State, lane buffer, chaining state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      last_q  <= 1'b0;
      good_q  <= 1'b0;
      for (int i = 0; i < 25; i++) begin
        chain_q[i] <= '0;
        os_q[i]    <= '0;
      end
      for (int i = 0; i < RATE_LANES; i++) begin
        lane_buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      good_q  <= issue_s;
      if (lane_fire_s) begin
        lane_buf_q[idx_q] <= lane_in;
      end
      if (issue_s) begin
        for (int i = 0; i < 25; i++) begin
          os_q[i] <= os_next_s[i];
        end
      end
      // The last block of a message hands back a cleared state for the next message.
      if (fb_take_s) begin
        for (int i = 0; i < 25; i++) begin
          chain_q[i] <= last_q ? 64'h0 : fb_s[i];
        end
      end
    end
  end

  // Output mapping: lane i sits at row i/5, column i%5.
  always_comb begin
    for (int c = 0; c < 5; c++) begin
      osa[c] = os_q[c];
      osb[c] = os_q[5 + c];
      osc[c] = os_q[10 + c];
      osd[c] = os_q[15 + c];
      ose[c] = os_q[20 + c];
    end
    lane_ready = (state_q == COLLECT) && !rst;
    busy       = (state_q != COLLECT) && !rst;
    good       = good_q;
  end

endmodule

// File: tb/tb_sha3_absorb.sv
// Self-checking bench for sha3_absorb: directed table of blocks, hand sequences for
// reset/feedback corners, and randomized blocks against a chaining-state model.
module tb_sha3_absorb;

  localparam int RL = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] lane_in;
  logic        lane_valid;
  logic        lane_ready;
  logic        msg_last;
  logic [63:0] fba [0:4];
  logic [63:0] fbb [0:4];
  logic [63:0] fbc [0:4];
  logic [63:0] fbd [0:4];
  logic [63:0] fbe [0:4];
  logic        fb_good;
  logic [63:0] osa [0:4];
  logic [63:0] osb [0:4];
  logic [63:0] osc [0:4];
  logic [63:0] osd [0:4];
  logic [63:0] ose [0:4];
  logic        good;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_chain [25];
  logic [63:0] msg     [RL];
  logic [63:0] fbv     [25];
  logic [63:0] dut_os  [25];
  logic [63:0] cap     [25];
  logic [63:0] cap_ref [25];

  typedef struct {
    logic [63:0] base;
    logic [63:0] step;
    bit          last;
    logic [63:0] fb;
    logic [63:0] e0;
    logic [63:0] e16;
    logic [63:0] e24;
  } vec_t;

  vec_t tbl [6];

  sha3_absorb #(.RATE_LANES(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .lane_in    (lane_in),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .msg_last   (msg_last),
    .fba        (fba),
    .fbb        (fbb),
    .fbc        (fbc),
    .fbd        (fbd),
    .fbe        (fbe),
    .fb_good    (fb_good),
    .osa        (osa),
    .osb        (osb),
    .osc        (osc),
    .osd        (osd),
    .ose        (ose),
    .good       (good),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < 5; c++) begin
      dut_os[c]      = osa[c];
      dut_os[5 + c]  = osb[c];
      dut_os[10 + c] = osc[c];
      dut_os[15 + c] = osd[c];
      dut_os[20 + c] = ose[c];
      fba[c] = fbv[c];
      fbb[c] = fbv[5 + c];
      fbc[c] = fbv[10 + c];
      fbd[c] = fbv[15 + c];
      fbe[c] = fbv[20 + c];
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_fb_all(input logic [63:0] v);
    for (int i = 0; i < 25; i++) fbv[i] = v;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    lane_valid = 1'b1;
    lane_in = rnd64();
    fb_good = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rst_lane_ready", {63'd0, lane_ready}, 64'd0);
      chk("rst_good", {63'd0, good}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    for (int i = 0; i < 25; i++) chk($sformatf("rst_os%0d", i), dut_os[i], 64'd0);
    rst = 1'b0;
    lane_valid = 1'b0;
    for (int i = 0; i < 25; i++) m_chain[i] = 64'd0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, lane_ready}, 64'd1);
  endtask

  task automatic send_lane(input logic [63:0] d, input bit last, input int gap_pct);
    int n;
    while ($urandom_range(99) < gap_pct) begin
      lane_valid = 1'b0;
      lane_in = rnd64();
      msg_last = 1'($urandom_range(1));
      @(negedge clk);
    end
    lane_valid = 1'b1;
    lane_in = d;
    msg_last = last;
    n = 0;
    while (!lane_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("lane_ready_wait", {63'd0, lane_ready}, 64'd1);
    @(negedge clk);
    lane_valid = 1'b0;
    lane_in = rnd64();
    msg_last = 1'($urandom_range(1));
  endtask

  // Sends msg[] as one block, checks the issued matrix, then optionally returns feedback fbv[].
  task automatic run_block(input string tag, input int gap_pct, input bit last,
                           input int fb_delay, input bit do_fb);
    logic [63:0] exp [25];
    for (int i = 0; i < 25; i++) exp[i] = m_chain[i] ^ ((i < RL) ? msg[i] : 64'd0);
    for (int i = 0; i < RL; i++)
      send_lane(msg[i], (i == RL - 1) ? last : 1'($urandom_range(1)), gap_pct);
    chk({tag, "_good_early"}, {63'd0, good}, 64'd0);
    chk({tag, "_ready_issue"}, {63'd0, lane_ready}, 64'd0);
    chk({tag, "_busy_issue"}, {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk({tag, "_good"}, {63'd0, good}, 64'd1);
    for (int i = 0; i < 25; i++) begin
      cap[i] = dut_os[i];
      chk($sformatf("%s_lane%0d", tag, i), dut_os[i], exp[i]);
    end
    if (do_fb) begin
      for (int k = 0; k < fb_delay; k++) begin
        @(negedge clk);
        chk({tag, "_good_pulse"}, {63'd0, good}, 64'd0);
        chk({tag, "_ready_wait"}, {63'd0, lane_ready}, 64'd0);
        chk({tag, "_busy_wait"}, {63'd0, busy}, 64'd1);
      end
      fb_good = 1'b1;
      @(negedge clk);
      fb_good = 1'b0;
      chk({tag, "_good_after_fb"}, {63'd0, good}, 64'd0);
      chk({tag, "_ready_after_fb"}, {63'd0, lane_ready}, 64'd1);
      chk({tag, "_busy_after_fb"}, {63'd0, busy}, 64'd0);
      chk({tag, "_os_hold"}, dut_os[0], exp[0]);
      for (int i = 0; i < 25; i++) m_chain[i] = last ? 64'd0 : fbv[i];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'h0100_0000_0000_0000, 64'd1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF,
               64'h0100_0000_0000_0000, 64'h0100_0000_0000_0010, 64'd0};
    tbl[1] = '{64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'd0, 64'd0};
    tbl[2] = '{64'd0, 64'd0, 1'b1, 64'h1234_5678_9ABC_DEF0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{64'd0, 64'd0, 1'b1, 64'h5555_5555_5555_5555,
               64'd0, 64'd0, 64'd0};
    tbl[4] = '{64'h00FF_00FF_00FF_00FF, 64'h0000_0000_0000_0100, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F,
               64'h00FF_00FF_00FF_00FF, 64'h00FF_00FF_00FF_10FF, 64'd0};
    tbl[5] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'd0, 1'b1, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F};

    rst = 1'b1;
    lane_valid = 1'b0;
    lane_in = 64'd0;
    msg_last = 1'b0;
    fb_good = 1'b0;
    set_fb_all(64'd0);
    for (int i = 0; i < 25; i++) m_chain[i] = 64'd0;

    do_reset(3);

    // Directed table: single block, chaining through all-ones, clear on last block.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < RL; i++) msg[i] = tbl[k].base + tbl[k].step * 64'(i);
      set_fb_all(tbl[k].fb);
      run_block($sformatf("tbl%0d", k), 0, tbl[k].last, k % 3, 1'b1);
      chk($sformatf("tbl%0d_e0", k), cap[0], tbl[k].e0);
      chk($sformatf("tbl%0d_e16", k), cap[16], tbl[k].e16);
      chk($sformatf("tbl%0d_e24", k), cap[24], tbl[k].e24);
    end

    // Spurious feedback in COLLECT must not reach the chaining state.
    set_fb_all(64'hDEAD_DEAD_DEAD_DEAD);
    fb_good = 1'b1;
    @(negedge clk);
    fb_good = 1'b0;
    for (int i = 0; i < RL; i++) msg[i] = rnd64();
    run_block("spur", 0, 1'b1, 1, 1'b1);
    chk("spur_cap24", cap[24], 64'd0);

    // Same message with and without source gaps must issue the same matrix.
    for (int i = 0; i < RL; i++) msg[i] = rnd64();
    run_block("nogap", 0, 1'b1, 2, 1'b1);
    for (int i = 0; i < 25; i++) cap_ref[i] = cap[i];
    run_block("gap", 50, 1'b1, 2, 1'b1);
    for (int i = 0; i < 25; i++) chk($sformatf("gap_same%0d", i), cap[i], cap_ref[i]);

    // Reset after 8 lanes: the next 17 lanes form a fresh block.
    for (int i = 0; i < 8; i++) send_lane(rnd64(), 1'b0, 0);
    do_reset(1);
    for (int i = 0; i < RL; i++) msg[i] = rnd64();
    set_fb_all(rnd64());
    run_block("rst8", 0, 1'b0, 0, 1'b1);

    // Reset while waiting for feedback: late feedback is ignored.
    for (int i = 0; i < RL; i++) msg[i] = rnd64();
    run_block("rstwait", 0, 1'b0, 0, 1'b0);
    do_reset(2);
    set_fb_all(64'hDEAD_BEEF_0000_FFFF);
    fb_good = 1'b1;
    @(negedge clk);
    fb_good = 1'b0;
    chk("late_fb_busy", {63'd0, busy}, 64'd0);
    chk("late_fb_ready", {63'd0, lane_ready}, 64'd1);
    for (int i = 0; i < RL; i++) msg[i] = rnd64();
    run_block("after_late", 0, 1'b1, 1, 1'b1);
    chk("after_late_cap20", cap[20], 64'd0);

    // Randomized blocks against the chaining model.
    for (int b = 0; b < 24; b++) begin
      if ($urandom_range(99) < 30) begin
        for (int i = 0; i < 25; i++) fbv[i] = rnd64();
        fb_good = 1'b1;
        @(negedge clk);
        fb_good = 1'b0;
      end
      for (int i = 0; i < RL; i++) msg[i] = rnd64();
      for (int i = 0; i < 25; i++) fbv[i] = rnd64();
      run_block($sformatf("rnd%0d", b), $urandom_range(60), 1'($urandom_range(1)),
                $urandom_range(3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
